// File: rtl/uart_tx_engine.sv
// UART transmit engine: one-entry host holding register with a pending flag,
// feeding a start / LSB-first data / optional parity / stop frame serializer.
module uart_tx_engine #(
    parameter int BAUD_DIV   = 5208,
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       tx_rdy,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0]  DATA_MASK = 8'((1 << DATA_BITS) - 1);

    // Parity over the active data bits only; the odd/even sense folds in here.
    function automatic logic frame_parity(input logic [7:0] d);
        return (^(d & DATA_MASK)) ^ PARITY_ODD;
    endfunction

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic        pending, pending_n;
    logic [7:0]  hold, hold_n;
    logic [7:0]  shift, shift_n;
    logic        par, par_n;
    logic        tx_n, busy_n, done_n, rdy_n;
    logic        baud_last;
    logic        load_take;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign load_take = load & tx_rdy;

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + 16'd1;
        bit_cnt_n  = bit_cnt;
        pending_n  = pending;
        hold_n     = hold;
        shift_n    = shift;
        par_n      = par;

        // load is only taken while pending is clear and transfers only happen
        // while it is set, so the two updates below never collide.
        if (load_take) begin
            pending_n = 1'b1;
            hold_n    = data_in;
        end

        case (state)
            IDLE: begin
                baud_cnt_n = 16'd0;
                if (pending) begin
                    shift_n   = hold;
                    par_n     = frame_parity(hold);
                    pending_n = 1'b0;
                    bit_cnt_n = 3'd0;
                    state_n   = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_n = 16'd0;
                    bit_cnt_n  = 3'd0;
                    state_n    = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_n = 16'd0;
                    shift_n    = {1'b0, shift[7:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_n = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    baud_cnt_n = 16'd0;
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_n = 16'd0;
                    // A waiting byte goes straight into the next start bit.
                    if (pending) begin
                        shift_n   = hold;
                        par_n     = frame_parity(hold);
                        pending_n = 1'b0;
                        bit_cnt_n = 3'd0;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                baud_cnt_n = 16'd0;
                state_n    = IDLE;
            end
        endcase

        tx_n = 1'b1;
        case (state)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift[0];
            PARITY:  tx_n = par;
            default: tx_n = 1'b1;
        endcase
        busy_n = (state != IDLE);
        done_n = (state == STOP) && baud_last;
        rdy_n  = ~pending_n;
    end

    // Registered control and line outputs; these lag the state by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            pending  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_rdy   <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            pending  <= pending_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
            tx_rdy   <= rdy_n;
        end
    end

    // Data registers carry no reset; pending and state qualify their use.
    always_ff @(posedge clk) begin
        hold  <= hold_n;
        shift <= shift_n;
        par   <= par_n;
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: four parameterisations, a frame
// scoreboard fed at load time and drained by per-instance serial monitors.
module tb_uart_tx_engine;

    localparam int BD = 4;

    typedef struct {
        int          inst;
        logic [10:0] bits;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] load_v;
    logic [7:0] din [4];
    wire  [3:0] tx_v, busy_v, done_v, rdy_v;

    exp_t expq[$];
    int   chks;
    int   errs;
    int   frames [4];
    int   start_gap [4];

    uart_tx_engine #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .reset(reset), .load(load_v[0]), .data_in(din[0]),
        .tx_rdy(rdy_v[0]), .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]));
    uart_tx_engine #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
        .clk(clk), .reset(reset), .load(load_v[1]), .data_in(din[1]),
        .tx_rdy(rdy_v[1]), .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]));
    uart_tx_engine #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
        .clk(clk), .reset(reset), .load(load_v[2]), .data_in(din[2]),
        .tx_rdy(rdy_v[2]), .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]));
    uart_tx_engine #(.BAUD_DIV(BD), .DATA_BITS(5), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u3 (
        .clk(clk), .reset(reset), .load(load_v[3]), .data_in(din[3]),
        .tx_rdy(rdy_v[3]), .busy(busy_v[3]), .done(done_v[3]), .tx(tx_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbits(input int i);
        return (i == 3) ? 5 : 8;
    endfunction

    function automatic int pen(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction

    function automatic logic pod(input int i);
        return (i == 2);
    endfunction

    function automatic int flen(input int i);
        return 2 + nbits(i) + pen(i);
    endfunction

    // Line level for each bit period of a frame, index 0 = start bit.
    function automatic logic [10:0] mk_frame(input int i, input logic [7:0] d);
        logic [10:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = pod(i);
        for (int k = 0; k < nbits(i); k++) begin
            f[k + 1] = d[k];
            p        = p ^ d[k];
        end
        if (pen(i) == 1) f[nbits(i) + 1] = p;
        return f;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_frame(input int i, input logic [7:0] d);
        exp_t e;
        e.inst = i;
        e.bits = mk_frame(i, d);
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int i, input logic [7:0] d);
        load_v[i] = 1'b1;
        din[i]    = d;
        @(negedge clk);
        load_v[i] = 1'b0;
    endtask

    // Follows one instance's line; every frame cycle is compared against the
    // scoreboard entry popped at the falling start edge.
    task automatic monitor(input int i);
        bit          active;
        int          cyc;
        int          gap;
        int          len;
        logic [10:0] cur;
        exp_t        e;
        active = 1'b0;
        cyc    = 0;
        gap    = 0;
        cur    = '1;
        len    = flen(i) * BD;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
                gap    = 0;
            end else begin
                if (!active && tx_v[i] === 1'b0) begin
                    start_gap[i] = gap;
                    gap    = 0;
                    active = 1'b1;
                    cyc    = 0;
                    check($sformatf("frame_expected_u%0d", i),
                          32'(expq.size() > 0 && expq[0].inst == i), 32'(1));
                    if (expq.size() > 0 && expq[0].inst == i) begin
                        e   = expq.pop_front();
                        cur = e.bits;
                    end else begin
                        cur = '1;
                    end
                end
                if (active) begin
                    check($sformatf("u%0d_bit%0d_cyc%0d_tx_busy_done", i, cyc / BD, cyc),
                          32'({tx_v[i], busy_v[i], done_v[i]}),
                          32'({cur[cyc / BD], 1'b1, (cyc == len - 1)}));
                    cyc++;
                    if (cyc == len) begin
                        active = 1'b0;
                        frames[i]++;
                    end
                end else begin
                    gap++;
                    check($sformatf("u%0d_idle_busy_done", i),
                          32'({busy_v[i], done_v[i]}), 32'(0));
                end
            end
        end
    endtask

    initial begin
        chks   = 0;
        errs   = 0;
        reset  = 1'b1;
        load_v = '0;
        for (int i = 0; i < 4; i++) begin
            din[i]       = 8'h00;
            frames[i]    = 0;
            start_gap[i] = -1;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none

        step(3);
        for (int i = 0; i < 4; i++)
            check($sformatf("reset_state_u%0d_tx_busy_done_rdy", i),
                  32'({tx_v[i], busy_v[i], done_v[i], rdy_v[i]}), 32'(4'b1001));
        reset = 1'b0;
        step(3);

        // Basic 8N1 frame and handshake latency
        expect_frame(0, 8'h55);
        do_load(0, 8'h55);
        check("t1_rdy_after_load", 32'(rdy_v[0]), 32'(0));
        check("t1_tx_idle_after_load", 32'(tx_v[0]), 32'(1));
        step(1);
        check("t1_rdy_after_transfer", 32'(rdy_v[0]), 32'(1));
        check("t1_tx_still_idle", 32'(tx_v[0]), 32'(1));
        step(1);
        check("t1_tx_start_busy", 32'({tx_v[0], busy_v[0]}), 32'(2'b01));
        step(44);
        check("t1_frames_done", 32'(frames[0]), 32'(1));

        // Even and odd parity
        expect_frame(1, 8'h07);
        do_load(1, 8'h07);
        step(50);
        check("t2_even_frames", 32'(frames[1]), 32'(1));
        expect_frame(2, 8'h07);
        do_load(2, 8'h07);
        step(50);
        check("t2_odd_frames", 32'(frames[2]), 32'(1));

        // Double buffering: second byte queued mid-frame, third one refused
        expect_frame(0, 8'hA3);
        do_load(0, 8'hA3);
        step(8);
        check("t3_rdy_mid_frame", 32'(rdy_v[0]), 32'(1));
        expect_frame(0, 8'h3C);
        do_load(0, 8'h3C);
        step(2);
        check("t3_rdy_while_pending", 32'(rdy_v[0]), 32'(0));
        do_load(0, 8'hFF);
        step(90);
        check("t3_frames_done", 32'(frames[0]), 32'(3));
        check("t3_back_to_back_gap", 32'(start_gap[0]), 32'(0));

        // Reset in the middle of the data bits
        expect_frame(0, 8'hF0);
        do_load(0, 8'hF0);
        step(14);
        reset = 1'b1;
        @(negedge clk);
        check("t4_after_reset_tx_busy_done_rdy",
              32'({tx_v[0], busy_v[0], done_v[0], rdy_v[0]}), 32'(4'b1001));
        reset = 1'b0;
        step(10);
        check("t4_line_idle", 32'(tx_v[0]), 32'(1));
        check("t4_no_frame_completed", 32'(frames[0]), 32'(3));
        expect_frame(0, 8'h12);
        do_load(0, 8'h12);
        step(46);
        check("t4_clean_frame_done", 32'(frames[0]), 32'(4));

        // Five data bits
        expect_frame(3, 8'hFF);
        do_load(3, 8'hFF);
        step(34);
        check("t5_frames_done", 32'(frames[3]), 32'(1));

        // load held three clocks: first and third accepted, middle dropped
        expect_frame(0, 8'h11);
        expect_frame(0, 8'h33);
        load_v[0] = 1'b1;
        din[0]    = 8'h11;
        @(negedge clk);
        din[0]    = 8'h22;
        @(negedge clk);
        din[0]    = 8'h33;
        @(negedge clk);
        load_v[0] = 1'b0;
        step(90);
        check("t6_frames_done", 32'(frames[0]), 32'(6));
        check("t6_back_to_back_gap", 32'(start_gap[0]), 32'(0));

        check("scoreboard_empty", 32'(expq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Serial transmit engine that consumes a latched "transmit request" and clears it when the request is taken.
- Host side: pulses `load` with a byte. The block holds it in a one-entry holding register guarded by a set/clear pending flag.
- Line side: shifts the byte out as a UART frame: start, LSB-first data, optional parity, one stop bit.
- Signals frame completion and re-arms the host handshake.
- Sits between the CPU/register interface and the TX pad.

Parameters:
- BAUD_DIV, 5208, clocks per bit period (50 MHz / 9600 baud); legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 = insert parity bit after data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle write strobe from host.
- data_in  input  8  byte to send; bits above DATA_BITS-1 ignored.
- tx_rdy  output  1  1 = holding register empty, load will be accepted.
- busy  output  1  1 = a frame is on the line (start through stop).
- done  output  1  one-cycle pulse on the last clock of each stop bit.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (clk edge with reset=1) forces: tx=1, busy=0, done=0, tx_rdy=1, pending=0, state=IDLE, baud counter=0, bit counter=0. Reset overrides load and any frame in progress. The line returns high on the next clock with no partial stop bit.
- Pending flag (SR behaviour):
  - Set by load when tx_rdy=1; data_in is captured into the holding register the same edge.
  - Cleared when the engine transfers the holding register into the shift register.
  - load while tx_rdy=0 is ignored: holding data unchanged, no error flag.
  - Set and clear cannot coincide, because load is only accepted when pending=0 and transfer only occurs when pending=1.
  - tx_rdy = ~pending, registered.
- States: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state lasts exactly BAUD_DIV clocks, timed by a baud counter.
  - The counter resets to 0 on every state entry and the state advances when the counter reaches BAUD_DIV-1.
- IDLE: tx=1, busy=0. If pending=1: transfer holding to shift register, clear pending, compute parity over DATA_BITS bits, go to START.
- START: tx=0.
- DATA: tx = shift[0]; shift right once per bit. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of data bits, XOR PARITY_ODD.
- STOP: tx=1. On its last clock, done=1 for exactly one cycle. Then:
  - if pending=1, transfer and go directly to START, so back-to-back frames have no idle gap;
  - otherwise go to IDLE.
- busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Latency: load accepted at edge N → tx_rdy=0 after edge N → transfer at edge N+1 (tx_rdy back to 1) → tx=0 from edge N+2.
- Frame length: (2 + DATA_BITS + PARITY_EN) × BAUD_DIV clocks.
- Outputs tx, busy, done and tx_rdy are all registered; no combinational path from load or data_in.
- The holding register is loadable during a frame (double buffering). Its contents are not visible on tx until transfer.

Test Plan:
1. Reset, then BAUD_DIV=4, load data_in=0x55 → tx low for 4 clocks starting 2 clocks after load, then 1,0,1,0,1,0,1,0 (4 clocks each), stop high for 4 clocks. done pulses once at clock 40 of the frame; busy high for 40 clocks.
2. PARITY_EN=1, PARITY_ODD=0, load 0x07 → parity bit=1; with PARITY_ODD=1 → parity bit=0; frame is 44 clocks at BAUD_DIV=4.
3. Load 0xA3, then load 0x3C mid-frame while tx_rdy=1, then load 0xFF while tx_rdy=0 → frames 0xA3 and 0x3C are contiguous (no idle clock between stop and start); 0xFF is never transmitted.
4. Assert reset during the DATA state of 0xF0 → next clock: tx=1, busy=0, tx_rdy=1, no done pulse; a subsequent load of 0x12 sends a clean frame.
5. DATA_BITS=5, load 0xFF → only 5 data bits sent; frame is 7×BAUD_DIV clocks.
6. Load held high for 3 consecutive clocks with 0x11, 0x22, 0x33 while idle → 0x11 sent; 0x33 captured on the third clock after the first transfer and sent next; 0x22 dropped.
